// File: rtl/register_file_if.sv
// Register file port bundle: read/write addresses, data, debug port and write counter.
interface register_file_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
);
    localparam int unsigned AW = $clog2(NREG);

    logic [AW-1:0]   A1;
    logic [AW-1:0]   A2;
    logic [AW-1:0]   A3;
    logic [XLEN-1:0] WD3;
    logic            WE3;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic [AW-1:0]   DbgA;
    logic [XLEN-1:0] DbgRD;
    logic [31:0]     WrCount;

    modport master (
        output A1, A2, A3, WD3, WE3, DbgA,
        input  RD1, RD2, DbgRD, WrCount
    );

    modport slave (
        input  A1, A2, A3, WD3, WE3, DbgA,
        output RD1, RD2, DbgRD, WrCount
    );
endinterface

// File: rtl/register_file.sv
// Architectural integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, a never-bypassed debug read
// port and a wrapping count of committed writes to non-zero registers.
// Optional macro REGFILE_BYPASS_EN forwards WD3 to RD1/RD2 when the read
// address matches a pending valid write.
module register_file #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input logic            clk,
    input logic            rst,
    register_file_if.slave bus
);
    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [31:0]     wr_count;
    logic            wr_valid;

    // A write commits only when enabled and not aimed at x0
    assign wr_valid = bus.WE3 && (bus.A3 != AW'(0));

    // Storage update; reset clears every register ahead of any write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[bus.A3] <= bus.WD3;
        end
    end

    // Committed-write counter, wraps modulo 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= 32'd0;
        end else if (wr_valid) begin
            wr_count <= wr_count + 32'd1;
        end
    end

    assign bus.WrCount = wr_count;

    // Combinational reads; x0 and reset force zero, debug port shows storage only
    always_comb begin
        bus.RD1   = '0;
        bus.RD2   = '0;
        bus.DbgRD = '0;
        if (!rst) begin
            if (bus.A1 != AW'(0)) begin
                bus.RD1 = regs[bus.A1];
            end
            if (bus.A2 != AW'(0)) begin
                bus.RD2 = regs[bus.A2];
            end
            if (bus.DbgA != AW'(0)) begin
                bus.DbgRD = regs[bus.DbgA];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_valid && (bus.A1 == bus.A3)) begin
                bus.RD1 = bus.WD3;
            end
            if (wr_valid && (bus.A2 == bus.A3)) begin
                bus.RD2 = bus.WD3;
            end
`endif
        end
    end
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed cases from the test plan
// plus randomized traffic against an array-based reference model.
module tb_register_file;
    logic clk;
    logic rst;

    register_file_if #(.XLEN(32), .NREG(32)) bus ();

    register_file #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    int          n_cmp;
    int          n_err;
    logic [31:0] mem [32];
    logic [31:0] count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        count = 32'd0;
    endtask

    // Expected read value from the architectural rules
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit fwd);
        if (rst || a == 5'd0) return 32'd0;
        if (fwd && BYPASS && bus.WE3 && bus.A3 != 5'd0 && a == bus.A3) return bus.WD3;
        return mem[a];
    endfunction

    // Inputs already driven (at negedge): check outputs, clock one edge, update model
    task automatic step(input string tag);
        #1;
        check({tag, "_rd1"}, bus.RD1, exp_rd(bus.A1, 1'b1));
        check({tag, "_rd2"}, bus.RD2, exp_rd(bus.A2, 1'b1));
        check({tag, "_dbg"}, bus.DbgRD, exp_rd(bus.DbgA, 1'b0));
        check({tag, "_cnt"}, bus.WrCount, count);
        @(posedge clk);
        if (!rst && bus.WE3 && bus.A3 != 5'd0) begin
            mem[bus.A3] = bus.WD3;
            count = count + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] da);
        bus.WE3  = we;
        bus.A3   = a3;
        bus.WD3  = wd;
        bus.A1   = a1;
        bus.A2   = a2;
        bus.DbgA = da;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0]  a1, a2, a3;
        logic [31:0] pat;
        n_cmp = 0;
        n_err = 0;
        model_clear();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd5);
        #1;
        check("por_rd1", bus.RD1, 32'd0);
        check("por_cnt", bus.WrCount, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset clear: commit x5, then assert reset mid-cycle with a write pending
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
        step("wr5");
        drive(1'b1, 5'd9, 32'hCAFEF00D, 5'd5, 5'd9, 5'd5);
        step("pre_rst");
        rst = 1'b1;
        #1;
        check("rst_rd1_x5", bus.RD1, 32'd0);
        check("rst_dbg_x5", bus.DbgRD, 32'd0);
        check("rst_cnt", bus.WrCount, 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd5, 5'd9);
        step("post_rst");

        // Basic write/read
        drive(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0, 5'd0);
        step("wr7");
        drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);
        #1;
        check("basic_rd1", bus.RD1, 32'h12345678);
        check("basic_rd2", bus.RD2, 32'h12345678);
        check("basic_cnt", bus.WrCount, 32'd1);
        step("basic");

        // x0 protection
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        step("wr0");
        #1;
        check("x0_rd1", bus.RD1, 32'd0);
        check("x0_cnt", bus.WrCount, 32'd1);

        // Same-cycle read during write
        drive(1'b1, 5'd3, 32'h11, 5'd0, 5'd0, 5'd0);
        step("wr3a");
        drive(1'b1, 5'd3, 32'h22, 5'd3, 5'd3, 5'd3);
        #1;
        check("rdw_rd1", bus.RD1, BYPASS ? 32'h22 : 32'h11);
        check("rdw_rd2", bus.RD2, BYPASS ? 32'h22 : 32'h11);
        check("rdw_dbg", bus.DbgRD, 32'h11);
        step("rdw");
        drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 5'd3);
        #1;
        check("rdw_after", bus.RD1, 32'h22);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            a3 = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), a3, $urandom, a1, a2, 5'($urandom_range(0, 31)));
            step("rand");
        end

        // Counter wrap: preload the counter and commit two writes
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        force dut.wr_count = 32'hFFFFFFFE;
        #1;
        release dut.wr_count;
        count = 32'hFFFFFFFE;
        drive(1'b1, 5'd10, 32'hA5A5A5A5, 5'd10, 5'd11, 5'd10);
        step("wrap1");
        drive(1'b1, 5'd11, 32'h5A5A5A5A, 5'd10, 5'd11, 5'd11);
        step("wrap2");
        drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd11, 5'd11);
        #1;
        check("wrap_cnt", bus.WrCount, 32'h00000000);

        // Full sweep from a clean state
        pulse_reset();
        for (int i = 1; i < 32; i++) begin
            pat = 32'(i) * 32'h01010101;
            drive(1'b1, 5'(i), pat, 5'd0, 5'd0, 5'd0);
            step("sweep_wr");
        end
        for (int i = 0; i < 32; i++) begin
            pat = 32'(i) * 32'h01010101;
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 5'(i));
            #1;
            check("sweep_rd1", bus.RD1, pat);
            check("sweep_rd2", bus.RD2, pat);
            check("sweep_dbg", bus.DbgRD, pat);
            step("sweep_rd");
        end
        check("sweep_cnt", bus.WrCount, 32'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
